uart_msg_arbiter: RTL
=====================

// Module: uart_msg_arbiter
// PURPOSE
//  Shares one AXI-Stream UART TX byte channel between N_REQ message sources.
//  Each source raises a one-cycle request; the block latches it, grants round-robin,
//  fetches that source's bytes from an async-read message store via (msg_sel, msg_index),
//  and streams a whole message atomically, with a programmable inter-byte gap. Sits between
//  detection/status logic and the UART transmitter.
// PARAMETERS
//  N_REQ       4    number of requesting sources (>=2)
//  N_BITS      8    byte width of message store and UART stream
//  MSG_LEN_MAX 32   max message length in bytes; LEN_W = $clog2(MSG_LEN_MAX+1)
//  GAP_CYCLES  7    idle cycles inserted after each accepted byte (0 = back-to-back)
// PORTS
//  clk          in   1               clock
//  rst          in   1               synchronous, active-high reset
//  req          in   N_REQ           per-source one-cycle send request
//  done         out  N_REQ           one-cycle pulse: source's message fully accepted
//  busy         out  1               high while a message is in progress (LOAD..DONE)
//  msg_sel      out  $clog2(N_REQ)   selected source, into message store
//  msg_index    out  $clog2(MSG_LEN_MAX) byte index, into message store
//  msg_data     in   N_BITS          store data for (msg_sel,msg_index), combinational
//  msg_len      in   LEN_W           length of message for msg_sel, combinational
//  uart_tdata   out  N_BITS          byte to transmit
//  uart_tvalid  out  1               byte valid
//  uart_tready  in   1               transmitter accepts byte
// BEHAVIOUR
//  - Reset: all outputs 0, pending=0, state IDLE, RR pointer=0 (source 0 highest priority).
//  - pending[i] set on req[i]; stays set until granted. Repeat req while pending is absorbed.
//    req of the source currently being served sets pending again (re-served later).
//  - FSM: IDLE -> ARB when |pending. ARB (1 cycle): grant first pending at/after pointer,
//    wrapping; msg_sel<=grant, clear pending[grant], pointer<=grant+1 mod N_REQ, index<=0.
//    LOAD: latch len<=msg_len; if len==0 -> DONE; else tdata<=msg_data, tvalid<=1 -> SEND.
//    SEND: hold tdata/tvalid stable until tready. On tvalid&tready: tvalid<=0, index++;
//    if index==len-1 -> DONE (or TERM) else GAP (or LOAD directly when GAP_CYCLES==0).
//    GAP: count GAP_CYCLES cycles, then LOAD. DONE: done[msg_sel] pulses 1 cycle -> IDLE.
//  - Min byte-to-byte spacing: 1 (accept) + GAP_CYCLES + 1 (LOAD) cycles.
//  - msg_len>MSG_LEN_MAX saturates to MSG_LEN_MAX. msg_len is sampled once per byte LOAD
//    and must be static per message; only the first LOAD value is used.
//  - rst mid-message: tvalid drops next edge, message abandoned, no done pulse.
//  - tvalid never deasserts without handshake (AXI-Stream compliant).
// CONFIGURATION
//  UART_MSG_TERM_EN defined: after last message byte, TERM state sends 8'h0D then 8'h0A
//   (same handshake + GAP rules) before DONE. Undefined: no terminator, SEND -> DONE.
// STRUCTURE
//  Package uart_msg_pkg: FSM state enum (IDLE,ARB,LOAD,SEND,GAP,TERM,DONE), CR/LF constants,
//   width helper functions. Sub-module rr_arbiter (N_REQ pending in, pointer, one-hot/
//   binary grant out, combinational).
// TESTING
//  1 Single: len=3 for src1, GAP=7, tready=1 -> 3 bytes, 9-cycle spacing, done[1] once.
//  2 Contention: req=4'b1111 same cycle after reset -> order 0,1,2,3; next burst 0,1,2,3.
//  3 Backpressure: tready low 5 cycles on byte 2 -> tdata/tvalid held stable, no skip.
//  4 len=0 for src2 -> no tvalid, done[2] pulses 3 cycles after req (ARB,LOAD,DONE).
//  5 rst asserted during byte 2 of 4 -> tvalid=0 next cycle, pending=0, no done.
//  6 UART_MSG_TERM_EN: len=2 "OK" -> bytes 4F,4B,0D,0A then done.

Source files
------------

// File: rtl/uart_msg_arbiter_pkg.sv
// Shared types and helpers for the UART message arbiter:
// FSM state encoding, CR/LF terminator bytes and width helper functions.
package uart_msg_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARB,
      ST_LOAD,
      ST_SEND,
      ST_GAP,
      ST_TERM,
      ST_DONE
   } state_t;

   localparam logic [7:0] CR_BYTE = 8'h0D;
   localparam logic [7:0] LF_BYTE = 8'h0A;

   // Width of an index selecting one of n items (never below 1 bit).
   function automatic int sel_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Width of a counter holding 0..n inclusive (never below 1 bit).
   function automatic int cnt_w(input int n);
      return (n > 0) ? $clog2(n + 1) : 1;
   endfunction

endpackage

// File: rtl/uart_msg_arbiter_if.sv
// Bundle of request/done, message-store and AXI-Stream UART signals for
// uart_msg_arbiter. master = the arbiter, slave = sources/store/transmitter.
interface uart_msg_arbiter_if #(
   parameter int N_REQ       = 4,
   parameter int N_BITS      = 8,
   parameter int MSG_LEN_MAX = 32
);
   localparam int SEL_W = uart_msg_pkg::sel_w(N_REQ);
   localparam int IDX_W = uart_msg_pkg::sel_w(MSG_LEN_MAX);
   localparam int LEN_W = uart_msg_pkg::cnt_w(MSG_LEN_MAX);

   logic [N_REQ-1:0]  req;
   logic [N_REQ-1:0]  done;
   logic              busy;
   logic [SEL_W-1:0]  msg_sel;
   logic [IDX_W-1:0]  msg_index;
   logic [N_BITS-1:0] msg_data;
   logic [LEN_W-1:0]  msg_len;
   logic [N_BITS-1:0] uart_tdata;
   logic              uart_tvalid;
   logic              uart_tready;

   modport master (
      input  req, msg_data, msg_len, uart_tready,
      output done, busy, msg_sel, msg_index, uart_tdata, uart_tvalid
   );

   modport slave (
      output req, msg_data, msg_len, uart_tready,
      input  done, busy, msg_sel, msg_index, uart_tdata, uart_tvalid
   );

endinterface

// File: rtl/uart_msg_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set bit of pending at or after ptr,
// wrapping around. Returns the grant both one-hot and binary.
module rr_arbiter #(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0]                      pending,
   input  logic [uart_msg_pkg::sel_w(N_REQ)-1:0] ptr,
   output logic [N_REQ-1:0]                      grant_oh,
   output logic [uart_msg_pkg::sel_w(N_REQ)-1:0] grant_idx,
   output logic                                  grant_any
);
   localparam int SEL_W = uart_msg_pkg::sel_w(N_REQ);

   // Circular scan from the pointer; the first pending source found wins.
   always_comb begin
      int               k;
      logic [SEL_W-1:0] ks;
      // NOTE: every output gets a default before the scan so no path leaves it unassigned (no latch).
      grant_oh  = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      k         = 0;
      ks        = '0;
      for (int i = 0; i < N_REQ; i++) begin
         k = int'(ptr) + i;
         if (k >= N_REQ) k = k - N_REQ;
         ks = SEL_W'(k);
         if (!grant_any && pending[ks]) begin
            grant_any    = 1'b1;
            grant_oh[ks] = 1'b1;
            grant_idx    = ks;
         end
      end
   end

endmodule

// File: rtl/uart_msg_arbiter.sv
// uart_msg_arbiter: shares one AXI-Stream UART TX byte channel between N_REQ
// message sources. Requests are latched as pending, granted round-robin, and the
// granted source's message is streamed atomically with GAP_CYCLES idle cycles
// after each accepted byte.
// Optional feature: define UART_MSG_TERM_EN to append CR, LF after each
// non-empty message (same handshake and gap rules as message bytes).
module uart_msg_arbiter #(
   parameter int N_REQ       = 4,
   parameter int N_BITS      = 8,
   parameter int MSG_LEN_MAX = 32,
   parameter int GAP_CYCLES  = 7
) (
   input logic                clk,
   input logic                rst,
   uart_msg_arbiter_if.master bus
);
   import uart_msg_pkg::*;

   localparam int SEL_W = sel_w(N_REQ);
   localparam int IDX_W = sel_w(MSG_LEN_MAX);
   localparam int LEN_W = cnt_w(MSG_LEN_MAX);
   localparam int GAP_W = cnt_w(GAP_CYCLES);
   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MSG_LEN_MAX);

   state_t            state_q,   state_d;
   logic [N_REQ-1:0]  pending_q, pending_d;
   logic [SEL_W-1:0]  ptr_q,     ptr_d;
   logic [SEL_W-1:0]  sel_q,     sel_d;
   logic [IDX_W-1:0]  index_q,   index_d;
   logic [LEN_W-1:0]  len_q,     len_d;
   logic [N_BITS-1:0] tdata_q,   tdata_d;
   logic              tvalid_q,  tvalid_d;
   logic [GAP_W-1:0]  gap_q,     gap_d;
`ifdef UART_MSG_TERM_EN
   logic              term_q,    term_d;   // terminator bytes being sent
   logic              lf_q,      lf_d;     // CR accepted, LF is next
`endif

   logic [N_REQ-1:0]  grant_oh;
   logic [SEL_W-1:0]  grant_idx;
   logic              grant_any;
   logic [LEN_W-1:0]  len_sat;
   logic [LEN_W-1:0]  len_eff;
   logic              last_byte;

   rr_arbiter #(.N_REQ(N_REQ)) u_rr (
      .pending   (pending_q),
      .ptr       (ptr_q),
      .grant_oh  (grant_oh),
      .grant_idx (grant_idx),
      .grant_any (grant_any)
   );

   // Over-long lengths clamp to the store size; only the first LOAD of a message
   // (index 0) takes the live length, later LOADs reuse the latched one.
   assign len_sat   = (bus.msg_len > LEN_MAX) ? LEN_MAX : bus.msg_len;
   assign len_eff   = (index_q == '0) ? len_sat : len_q;
   assign last_byte = (LEN_W'(index_q) == len_q - LEN_W'(1));

   // Next-state and datapath updates for the message FSM.
   always_comb begin
      state_d   = state_q;
      pending_d = pending_q | bus.req;
      ptr_d     = ptr_q;
      sel_d     = sel_q;
      index_d   = index_q;
      len_d     = len_q;
      tdata_d   = tdata_q;
      tvalid_d  = tvalid_q;
      gap_d     = gap_q;
`ifdef UART_MSG_TERM_EN
      term_d    = term_q;
      lf_d      = lf_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (|(pending_q | bus.req)) state_d = ST_ARB;
         end
         ST_ARB: begin
            if (grant_any) begin
               sel_d     = grant_idx;
               // A fresh req from the granted source in this same cycle re-arms it.
               pending_d = (pending_q & ~grant_oh) | bus.req;
               ptr_d     = (grant_idx == SEL_W'(N_REQ - 1)) ? '0 : grant_idx + SEL_W'(1);
               index_d   = '0;
`ifdef UART_MSG_TERM_EN
               term_d    = 1'b0;
               lf_d      = 1'b0;
`endif
               state_d   = ST_LOAD;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOAD: begin
            len_d = len_eff;
            if (len_eff == '0) begin
               state_d = ST_DONE;
            end else begin
               tdata_d  = bus.msg_data;
               tvalid_d = 1'b1;
               state_d  = ST_SEND;
            end
         end
         ST_SEND: begin
            // tvalid is high throughout SEND; hold everything until the handshake.
            if (bus.uart_tready) begin
               tvalid_d = 1'b0;
               gap_d    = '0;
`ifdef UART_MSG_TERM_EN
               if (term_q) begin
                  if (lf_q) begin
                     state_d = ST_DONE;
                  end else begin
                     lf_d    = 1'b1;
                     state_d = (GAP_CYCLES == 0) ? ST_TERM : ST_GAP;
                  end
               end else begin
                  index_d = index_q + IDX_W'(1);
                  if (last_byte) term_d = 1'b1;
                  if (GAP_CYCLES == 0) state_d = last_byte ? ST_TERM : ST_LOAD;
                  else                 state_d = ST_GAP;
               end
`else
               index_d = index_q + IDX_W'(1);
               if (last_byte)            state_d = ST_DONE;
               else if (GAP_CYCLES == 0) state_d = ST_LOAD;
               else                      state_d = ST_GAP;
`endif
            end
         end
         ST_GAP: begin
            if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
`ifdef UART_MSG_TERM_EN
               state_d = term_q ? ST_TERM : ST_LOAD;
`else
               state_d = ST_LOAD;
`endif
            end else begin
               gap_d = gap_q + GAP_W'(1);
            end
         end
`ifdef UART_MSG_TERM_EN
         ST_TERM: begin
            tdata_d  = lf_q ? N_BITS'(LF_BYTE) : N_BITS'(CR_BYTE);
            tvalid_d = 1'b1;
            state_d  = ST_SEND;
         end
`endif
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: the design holds only flops, no memory array, so every register is cleared by reset.
      if (rst) begin
         state_q   <= ST_IDLE;
         pending_q <= '0;
         ptr_q     <= '0;
         sel_q     <= '0;
         index_q   <= '0;
         len_q     <= '0;
         tdata_q   <= '0;
         tvalid_q  <= 1'b0;
         gap_q     <= '0;
`ifdef UART_MSG_TERM_EN
         term_q    <= 1'b0;
         lf_q      <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q   <= state_d;
         pending_q <= pending_d;
         ptr_q     <= ptr_d;
         sel_q     <= sel_d;
         index_q   <= index_d;
         len_q     <= len_d;
         tdata_q   <= tdata_d;
         tvalid_q  <= tvalid_d;
         gap_q     <= gap_d;
`ifdef UART_MSG_TERM_EN
         term_q    <= term_d;
         lf_q      <= lf_d;
`endif
      end
   end

   assign bus.msg_sel     = sel_q;
   assign bus.msg_index   = index_q;
   assign bus.uart_tdata  = tdata_q;
   assign bus.uart_tvalid = tvalid_q;
   assign bus.done        = (state_q == ST_DONE) ? (N_REQ'(1) << sel_q) : '0;
   assign bus.busy        = (state_q inside {ST_LOAD, ST_SEND, ST_GAP, ST_TERM, ST_DONE});

endmodule
